// File: rtl/memory_pkg.sv
// Shared definitions for the memory card game: default board geometry,
// pause length and the card/symbol/score types used at default sizes.
package memory_pkg;

    localparam int unsigned N_CARDS_DEF      = 16;
    localparam int unsigned SYM_W_DEF        = 3;
    localparam int unsigned SCORE_W_DEF      = 4;
    localparam int unsigned PAUSE_CYCLES_DEF = 50_000_000;
    localparam int unsigned IDX_W_DEF        = $clog2(N_CARDS_DEF);

    typedef logic [IDX_W_DEF-1:0]   card_idx_t;
    typedef logic [SYM_W_DEF-1:0]   sym_t;
    typedef logic [SCORE_W_DEF-1:0] score_t;

endpackage

// File: rtl/card_pick_enc.sv
// Lowest-index priority encoder over a card eligibility mask, with an
// optional single excluded index.
module card_pick_enc #(
    parameter int unsigned N     = 16,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     elig,
    input  logic             excl_en,
    input  logic [IDX_W-1:0] excl_idx,
    output logic [IDX_W-1:0] idx_c,
    output logic             valid_c
);

    // Scan from the top so the lowest eligible index is the last one written
    always_comb begin
        idx_c   = '0;
        valid_c = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (elig[i] && !(excl_en && (excl_idx == IDX_W'(i)))) begin
                idx_c   = IDX_W'(i);
                valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_board_dp.sv
// Memory card game datapath: board contents, face-up/matched flags, the two
// picks, post-miss pause timer, current player and scores.
// Optional build macro: MEMORY_STREAK_BONUS_EN (consecutive-match bonus).
module memory_board_dp
    import memory_pkg::*;
#(
    parameter int unsigned N_CARDS      = N_CARDS_DEF,
    parameter int unsigned SYM_W        = SYM_W_DEF,
    parameter int unsigned PAUSE_CYCLES = PAUSE_CYCLES_DEF,
    parameter int unsigned SCORE_W      = SCORE_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_i,
    input  logic [N_CARDS*SYM_W-1:0]     card_values_i,
    input  logic [$clog2(N_CARDS)-1:0]   cursor_i,
    input  logic                         select_first_card_i,
    input  logic                         select_second_card_i,
    input  logic                         auto_select_first_i,
    input  logic                         auto_select_second_i,
    input  logic                         match_found_i,
    input  logic                         start_pause_i,
    input  logic                         end_turn_i,
    input  logic                         extra_turn_i,
    output logic                         cards_match_o,
    output logic                         auto_pick1_valid_o,
    output logic                         auto_pick2_valid_o,
    output logic                         pause_done_o,
    output logic                         match_happened_o,
    output logic                         sel_ok_o,
    output logic [N_CARDS-1:0]           face_up_o,
    output logic [N_CARDS-1:0]           matched_o,
    output logic                         player_o,
    output logic [SCORE_W-1:0]           score0_o,
    output logic [SCORE_W-1:0]           score1_o,
    output logic                         game_over_o
);

    localparam int unsigned IDX_W = $clog2(N_CARDS);
    localparam int unsigned CNT_W = (PAUSE_CYCLES > 2) ? $clog2(PAUSE_CYCLES) : 1;
    localparam int unsigned SUM_W = SCORE_W + 1;

    logic [N_CARDS-1:0][SYM_W-1:0]   board_q, board_d;
    logic [N_CARDS-1:0]              face_up_q, face_up_d;
    logic [N_CARDS-1:0]              matched_q, matched_d;
    logic [IDX_W-1:0]                first_q, first_d;
    logic [IDX_W-1:0]                second_q, second_d;
    logic                            player_q, player_d;
    logic [1:0][SCORE_W-1:0]         score_q, score_d;
    logic                            game_over_q;
    logic                            match_happened_q;
    logic                            match_take;
    logic [CNT_W-1:0]                cnt_q;
    logic                            pausing_q;
    logic                            pause_done_q;
`ifdef MEMORY_STREAK_BONUS_EN
    logic                            streak_q, streak_d;
`endif

    logic [N_CARDS-1:0]              eligible;
    logic [IDX_W-1:0]                auto1_idx, auto2_idx;
    logic                            auto1_valid, auto2_valid;
    logic [IDX_W-1:0]                first_cand, second_cand;
    logic                            first_stb, second_stb, pick_en;
    logic [1:0]                      score_inc;
    logic [SUM_W-1:0]                score_sum;
    logic [SCORE_W-1:0]              score_sat;

    assign eligible = ~(face_up_q | matched_q);

    card_pick_enc #(.N(N_CARDS), .IDX_W(IDX_W)) u_auto1 (
        .elig     (eligible),
        .excl_en  (1'b0),
        .excl_idx ('0),
        .idx_c    (auto1_idx),
        .valid_c  (auto1_valid)
    );

    card_pick_enc #(.N(N_CARDS), .IDX_W(IDX_W)) u_auto2 (
        .elig     (eligible),
        .excl_en  (1'b1),
        .excl_idx (first_q),
        .idx_c    (auto2_idx),
        .valid_c  (auto2_valid)
    );

    // Pick candidates and the status flags the controller branches on
    always_comb begin
        first_cand  = select_first_card_i ? cursor_i : auto1_idx;
        second_cand = auto_select_second_i ? auto2_idx : cursor_i;
        first_stb   = select_first_card_i | auto_select_first_i;
        second_stb  = select_second_card_i | auto_select_second_i;
        pick_en     = ~game_over_q & ~pausing_q;
    end

    assign cards_match_o      = (board_q[second_cand] == board_q[first_q]);
    assign sel_ok_o           = eligible[cursor_i] & ~game_over_q;
    assign auto_pick1_valid_o = auto1_valid;
    assign auto_pick2_valid_o = auto2_valid;

    // Saturating score increment for the current player
    always_comb begin
        score_inc = 2'd1;
`ifdef MEMORY_STREAK_BONUS_EN
        if (streak_q) begin
            score_inc = 2'd2;
        end
`endif
        score_sum = {1'b0, score_q[player_q]} + SUM_W'(score_inc);
        score_sat = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    end

    // Next state of board, flags, picks, player and scores by strobe priority
    always_comb begin
        board_d    = board_q;
        face_up_d  = face_up_q;
        matched_d  = matched_q;
        first_d    = first_q;
        second_d   = second_q;
        player_d   = player_q;
        score_d    = score_q;
        match_take = 1'b0;
`ifdef MEMORY_STREAK_BONUS_EN
        streak_d   = streak_q;
`endif
        if (load_i) begin
            board_d   = card_values_i;
            face_up_d = '0;
            matched_d = '0;
            first_d   = '0;
            second_d  = '0;
            player_d  = 1'b0;
            score_d   = '0;
`ifdef MEMORY_STREAK_BONUS_EN
            streak_d  = 1'b0;
`endif
        end else if (end_turn_i) begin
            if (!matched_q[first_q]) begin
                face_up_d[first_q] = 1'b0;
            end
            if (!matched_q[second_q]) begin
                face_up_d[second_q] = 1'b0;
            end
            if (!extra_turn_i) begin
                player_d = ~player_q;
            end
`ifdef MEMORY_STREAK_BONUS_EN
            streak_d = 1'b0;
`endif
        end else if (match_found_i) begin
            matched_d[first_q]  = 1'b1;
            matched_d[second_q] = 1'b1;
            score_d[player_q]   = score_sat;
            match_take          = 1'b1;
`ifdef MEMORY_STREAK_BONUS_EN
            streak_d = 1'b1;
`endif
        end else if (pick_en) begin
            if (first_stb) begin
                if (eligible[first_cand]) begin
                    first_d               = first_cand;
                    face_up_d[first_cand] = 1'b1;
                end
            end else if (second_stb) begin
                if (eligible[second_cand] && (second_cand != first_q)) begin
                    second_d               = second_cand;
                    face_up_d[second_cand] = 1'b1;
                end
            end
        end
    end

    // Game state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board_q          <= '0;
            face_up_q        <= '0;
            matched_q        <= '0;
            first_q          <= '0;
            second_q         <= '0;
            player_q         <= 1'b0;
            score_q          <= '0;
            game_over_q      <= 1'b0;
            match_happened_q <= 1'b0;
        end else begin
            board_q          <= board_d;
            face_up_q        <= face_up_d;
            matched_q        <= matched_d;
            first_q          <= first_d;
            second_q         <= second_d;
            player_q         <= player_d;
            score_q          <= score_d;
            game_over_q      <= &matched_d;
            match_happened_q <= match_take;
        end
    end

`ifdef MEMORY_STREAK_BONUS_EN
    // Consecutive-match tracker within one turn
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= 1'b0;
        end else begin
            streak_q <= streak_d;
        end
    end
`endif

    // Post-miss pause: count PAUSE_CYCLES-1 down to 0, then pulse done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            pausing_q    <= 1'b0;
            pause_done_q <= 1'b0;
        end else begin
            pause_done_q <= 1'b0;
            if (load_i) begin
                cnt_q     <= '0;
                pausing_q <= 1'b0;
            end else if (start_pause_i) begin
                cnt_q     <= CNT_W'(PAUSE_CYCLES - 1);
                pausing_q <= 1'b1;
            end else if (pausing_q) begin
                if (cnt_q == '0) begin
                    pausing_q    <= 1'b0;
                    pause_done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end
    end

    assign face_up_o        = face_up_q;
    assign matched_o        = matched_q;
    assign player_o         = player_q;
    assign score0_o         = score_q[0];
    assign score1_o         = score_q[1];
    assign game_over_o      = game_over_q;
    assign pause_done_o     = pause_done_q;
    assign match_happened_o = match_happened_q;

endmodule

// File: tb/tb_memory_board_dp.sv
// Scoreboard bench for memory_board_dp: a rule-level game model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_memory_board_dp;
    import memory_pkg::*;

    localparam int N  = 16;
    localparam int SW = 3;
    localparam int P  = 5;
    localparam int W  = 4;
    localparam int SMAX = (1 << W) - 1;

    typedef struct {
        bit rst_n, load, sf, ss, af, as, mf, sp, et, xt;
        int cursor;
    } stim_t;

    typedef struct {
        logic [N-1:0] fu, mt;
        int  player, s0, s1;
        bit  over, pd, mh, a1v, a2v, cm, sel;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 load_i;
    logic [N*SW-1:0]      card_values_i;
    card_idx_t            cursor_i;
    logic                 select_first_card_i, select_second_card_i;
    logic                 auto_select_first_i, auto_select_second_i;
    logic                 match_found_i, start_pause_i, end_turn_i, extra_turn_i;
    logic                 cards_match_o, auto_pick1_valid_o, auto_pick2_valid_o;
    logic                 pause_done_o, match_happened_o, sel_ok_o;
    logic [N-1:0]         face_up_o, matched_o;
    logic                 player_o;
    score_t               score0_o, score1_o;
    logic                 game_over_o;

    memory_board_dp #(.N_CARDS(N), .SYM_W(SW), .PAUSE_CYCLES(P), .SCORE_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .load_i(load_i), .card_values_i(card_values_i),
        .cursor_i(cursor_i), .select_first_card_i(select_first_card_i),
        .select_second_card_i(select_second_card_i), .auto_select_first_i(auto_select_first_i),
        .auto_select_second_i(auto_select_second_i), .match_found_i(match_found_i),
        .start_pause_i(start_pause_i), .end_turn_i(end_turn_i), .extra_turn_i(extra_turn_i),
        .cards_match_o(cards_match_o), .auto_pick1_valid_o(auto_pick1_valid_o),
        .auto_pick2_valid_o(auto_pick2_valid_o), .pause_done_o(pause_done_o),
        .match_happened_o(match_happened_o), .sel_ok_o(sel_ok_o), .face_up_o(face_up_o),
        .matched_o(matched_o), .player_o(player_o), .score0_o(score0_o), .score1_o(score1_o),
        .game_over_o(game_over_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    exp_t sb_q[$];
    bit driver_done = 1'b0;

    // Reference model: the game as a set of rules
    int sym[N];
    bit fu[N], mt[N];
    int first, second, player, sc[2];
    bit streak;
    int pause_left;
    bit pd, mh;
    int board_vals[N];

    function automatic bit elig(int i);
        return !fu[i] && !mt[i];
    endfunction

    function automatic int lowest(int excl);
        for (int i = 0; i < N; i++) if (elig(i) && i != excl) return i;
        return -1;
    endfunction

    function automatic bit all_matched();
        for (int i = 0; i < N; i++) if (!mt[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin sym[i] = 0; fu[i] = 0; mt[i] = 0; end
        first = 0; second = 0; player = 0; sc[0] = 0; sc[1] = 0;
        streak = 0; pause_left = 0; pd = 0; mh = 0;
    endtask

    task automatic model_expect(input stim_t s, output exp_t e);
        int cand;
        for (int i = 0; i < N; i++) begin e.fu[i] = fu[i]; e.mt[i] = mt[i]; end
        e.player = player; e.s0 = sc[0]; e.s1 = sc[1];
        e.over = all_matched(); e.pd = pd; e.mh = mh;
        e.a1v = (lowest(-1) >= 0);
        e.a2v = (lowest(first) >= 0);
        cand = s.as ? ((lowest(first) < 0) ? 0 : lowest(first)) : s.cursor;
        e.cm  = (sym[cand] == sym[first]);
        e.sel = elig(s.cursor) && !e.over;
    endtask

    task automatic model_step(input stim_t s);
        bit pausing_now, over;
        int idx, add;
        if (!s.rst_n) begin model_reset(); return; end
        if (s.load) begin
            model_reset();
            for (int i = 0; i < N; i++) sym[i] = board_vals[i];
            return;
        end
        pausing_now = (pause_left > 0);
        over = all_matched();
        pd = 0; mh = 0;
        if (s.sp) pause_left = P;
        else if (pause_left > 0) begin
            pause_left--;
            if (pause_left == 0) pd = 1;
        end
        if (s.et) begin
            if (!mt[first]) fu[first] = 0;
            if (!mt[second]) fu[second] = 0;
            if (!s.xt) player = 1 - player;
            streak = 0;
        end else if (s.mf) begin
            mt[first] = 1; mt[second] = 1;
            add = 1;
`ifdef MEMORY_STREAK_BONUS_EN
            if (streak) add = 2;
`endif
            sc[player] = (sc[player] + add > SMAX) ? SMAX : sc[player] + add;
            streak = 1; mh = 1;
        end else if (!over && !pausing_now) begin
            if (s.sf || s.af) begin
                idx = s.sf ? s.cursor : lowest(-1);
                if (idx >= 0 && elig(idx)) begin first = idx; fu[idx] = 1; end
            end else if (s.ss || s.as) begin
                idx = s.as ? lowest(first) : s.cursor;
                if (idx >= 0 && elig(idx) && idx != first) begin second = idx; fu[idx] = 1; end
            end
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the oldest prediction
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("face_up", longint'(face_up_o), longint'(e.fu));
            chk("matched", longint'(matched_o), longint'(e.mt));
            chk("player", longint'(player_o), longint'(e.player));
            chk("score0", longint'(score0_o), longint'(e.s0));
            chk("score1", longint'(score1_o), longint'(e.s1));
            chk("game_over", longint'(game_over_o), longint'(e.over));
            chk("pause_done", longint'(pause_done_o), longint'(e.pd));
            chk("match_happened", longint'(match_happened_o), longint'(e.mh));
            chk("auto1_valid", longint'(auto_pick1_valid_o), longint'(e.a1v));
            chk("auto2_valid", longint'(auto_pick2_valid_o), longint'(e.a2v));
            chk("cards_match", longint'(cards_match_o), longint'(e.cm));
            chk("sel_ok", longint'(sel_ok_o), longint'(e.sel));
        end
    end

    function automatic stim_t idle_s();
        stim_t s;
        s = '{rst_n: 1, load: 0, sf: 0, ss: 0, af: 0, as: 0, mf: 0, sp: 0, et: 0, xt: 0, cursor: 0};
        return s;
    endfunction

    task automatic cyc(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = s.rst_n; load_i = s.load;
        for (int i = 0; i < N; i++) card_values_i[i*SW +: SW] = SW'(board_vals[i]);
        cursor_i = card_idx_t'(s.cursor);
        select_first_card_i = s.sf; select_second_card_i = s.ss;
        auto_select_first_i = s.af; auto_select_second_i = s.as;
        match_found_i = s.mf; start_pause_i = s.sp; end_turn_i = s.et; extra_turn_i = s.xt;
        if (!s.rst_n) model_reset();
        model_expect(s, e);
        sb_q.push_back(e);
        model_step(s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(idle_s());
    endtask
    task automatic pick1(input int c);
        stim_t s = idle_s(); s.sf = 1; s.cursor = c; cyc(s);
    endtask
    task automatic pick2(input int c);
        stim_t s = idle_s(); s.ss = 1; s.cursor = c; cyc(s);
    endtask
    task automatic strobe(input bit mf, input bit sp, input bit et, input bit xt, input bit af, input bit as);
        stim_t s = idle_s(); s.mf = mf; s.sp = sp; s.et = et; s.xt = xt; s.af = af; s.as = as; cyc(s);
    endtask
    task automatic load_paired();
        stim_t s = idle_s();
        for (int i = 0; i < N; i++) board_vals[i] = i % (N / 2);
        s.load = 1; cyc(s);
    endtask

    initial begin
        stim_t s;
        model_reset();
        for (int i = 0; i < N; i++) board_vals[i] = 0;
        rst_n = 0; load_i = 0; card_values_i = '0; cursor_i = '0;
        select_first_card_i = 0; select_second_card_i = 0;
        auto_select_first_i = 0; auto_select_second_i = 0;
        match_found_i = 0; start_pause_i = 0; end_turn_i = 0; extra_turn_i = 0;

        s = idle_s(); s.rst_n = 0; cyc(s); cyc(s);
        idle(1);

        // Matching pair 3/11, then a miss 0/1 with pause and end of turn
        load_paired();
        pick1(3); pick2(11); strobe(1, 0, 0, 0, 0, 0); idle(2);
        pick1(0); pick2(1); strobe(0, 1, 0, 0, 0, 0); idle(6);
        strobe(0, 0, 1, 0, 0, 0); idle(1);

        // Auto-pick: cards 0-2 matched, card 4 face-up
        load_paired();
        for (int k = 0; k < 3; k++) begin pick1(k); pick2(k + 8); strobe(1, 0, 0, 0, 0, 0); end
        strobe(0, 0, 1, 1, 0, 0);
        pick1(4); strobe(0, 0, 0, 0, 1, 0); strobe(0, 0, 0, 0, 0, 1);
        strobe(0, 0, 1, 0, 0, 0);

        // Pick on a face-up card is ignored; two matches in one turn
        pick1(7); pick1(7); pick2(15); strobe(1, 0, 0, 0, 0, 0);
        pick1(6); pick2(14); strobe(1, 0, 0, 0, 0, 0); idle(1);

        // Score saturation by repeated match strobes
        for (int k = 0; k < 20; k++) strobe(1, 0, 0, 0, 0, 0);
        strobe(0, 0, 1, 0, 0, 0);

        // Reset in the middle of a pause: no done pulse afterwards
        strobe(0, 1, 0, 0, 0, 0); idle(2);
        s = idle_s(); s.rst_n = 0; cyc(s);
        idle(8);

        // Pick strobes during a pause are ignored; restart of a pause reloads
        load_paired();
        strobe(0, 1, 0, 0, 0, 0); pick1(2); idle(2);
        strobe(0, 1, 0, 0, 0, 0); idle(3); pick1(2); idle(3);

        // Complete game: all pairs matched, then every pick is ignored
        load_paired();
        for (int k = 0; k < N / 2; k++) begin pick1(k); pick2(k + N / 2); strobe(1, 0, 0, 1, 0, 0); end
        pick1(0); strobe(0, 0, 0, 0, 1, 0); strobe(0, 0, 0, 0, 0, 1); idle(2);

        // Randomized play
        load_paired();
        for (int t = 0; t < 4000; t++) begin
            s = idle_s();
            s.rst_n  = ($urandom_range(0, 499) != 0);
            s.load   = ($urandom_range(0, 149) == 0);
            s.sf     = ($urandom_range(0, 5) == 0);
            s.ss     = ($urandom_range(0, 5) == 0);
            s.af     = ($urandom_range(0, 11) == 0);
            s.as     = ($urandom_range(0, 11) == 0);
            s.mf     = ($urandom_range(0, 19) == 0);
            s.sp     = ($urandom_range(0, 39) == 0);
            s.et     = ($urandom_range(0, 17) == 0);
            s.xt     = ($urandom_range(0, 1) == 0);
            s.cursor = $urandom_range(0, N - 1);
            if (s.load) for (int i = 0; i < N; i++) board_vals[i] = $urandom_range(0, (1 << SW) - 1);
            cyc(s);
        end
        idle(2);
        driver_done = 1'b1;
    end

    // End of run: drain the scoreboard within a bounded time, then summarize
    initial begin
        wait (driver_done);
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/memory_board_dp.md
# memory_board_dp

Datapath for the two-player memory card game. It sits directly beneath the game-control state machine: it consumes the control strobes (select, auto-select, match, pause, end-turn) and produces the status flags the controller branches on (cards match, pause done, auto-pick valid, match happened). It owns board contents, face-up and matched flags, the two picks, the post-miss pause counter, current player and scores.

## Interface
- N_CARDS, default 16: number of cards on the board; always even.
- SYM_W, default 3: width of a card symbol.
- PAUSE_CYCLES, default 50_000_000: length of the post-miss pause in clk cycles (1 s at 50 MHz); must be ≥2.
- SCORE_W, default 4: width of each player's score.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- load_i  in  1  latch a new board from card_values_i and clear all game state.
- card_values_i  in  N_CARDS*SYM_W  card symbols; card k occupies bits [k*SYM_W +: SYM_W].
- cursor_i  in  $clog2(N_CARDS)  card currently highlighted by the player.
- select_first_card_i, select_second_card_i  in  1 each  manual pick strobes, using cursor_i.
- auto_select_first_i, auto_select_second_i  in  1 each  timeout pick strobes, using the auto-pick indices.
- match_found_i, start_pause_i, end_turn_i, extra_turn_i  in  1 each  control strobes.
- cards_match_o  out  1  combinational: the second-pick candidate's symbol equals the first pick's symbol.
- auto_pick1_valid_o, auto_pick2_valid_o  out  1 each  an eligible card exists for auto-pick 1 / 2.
- pause_done_o  out  1  registered one-cycle pulse when the pause expires.
- match_happened_o  out  1  registered one-cycle pulse, one cycle after match_found_i.
- sel_ok_o  out  1  combinational: cursor_i is eligible as the next pick.
- face_up_o, matched_o  out  N_CARDS each  per-card flags.
- player_o  out  1  current player.
- score0_o, score1_o  out  SCORE_W each  player scores.
- game_over_o  out  1  all cards matched.

## Operation
- Eligible card: not face-up and not matched. For the second pick, the card must also differ from first_idx.
- Auto-pick indices: auto1 is the lowest eligible card. auto2 is the lowest eligible card other than first_idx. The valid outputs are high when the corresponding index exists.
- Second-pick candidate: auto2 when auto_select_second_i is high, otherwise cursor_i. auto_select_second_i must not depend combinationally on cards_match_o.
- First pick (select_first or auto_select_first): store first_idx and set its face_up bit. A strobe whose card is ineligible is ignored.
- Second pick: store second_idx and set its face_up bit.
- match_found_i: set matched on both picks, then increment score[player_o].
  - Scores saturate at 2^SCORE_W−1.
  - extra_turn_i keeps the current player.
- start_pause_i: load the pause counter with PAUSE_CYCLES−1 and set pausing. On reaching 0 the block pulses pause_done_o and clears pausing.
- end_turn_i: clear face_up on both picks (matched cards stay up), then toggle player_o.
- game_over_o: asserted when matched_o is all ones. While it is high, every pick strobe is ignored.
- load_i: copy the symbols, clear all flags, scores, picks and counter, and set player_o to 0.

## Timing
- Reset values: all flags 0, scores 0, player_o 0, counter 0, pause_done_o 0, match_happened_o 0, game_over_o 0.
- All state updates happen on the clk edge following the strobe. Picks and face_up are visible one cycle later.
- Pause length: pause_done_o is high exactly PAUSE_CYCLES cycles after the edge that samples start_pause_i.
- Priority, highest first: load_i, then end_turn_i, then match_found_i, then pick strobes. Both select strobes asserted in one cycle: only the first pick is taken.
- start_pause_i while already pausing: the counter reloads; there is no early pause_done_o.
- Pick strobes while pausing are ignored.
- Reset mid-pause: the counter clears and no pause_done_o pulse is produced.

## Configuration
- MEMORY_STREAK_BONUS_EN defined: the second and each later consecutive match within one player's turn adds 2 (still saturating). The streak clears on end_turn_i and load_i.
- MEMORY_STREAK_BONUS_EN undefined: every match adds 1 and no streak register exists.

## Structure
- The shared package memory_pkg holds:
  - default N_CARDS, SYM_W, SCORE_W;
  - typedefs card_idx_t, sym_t, score_t;
  - the PAUSE_CYCLES default.
- Sub-module card_pick_enc: a parameterised lowest-index priority encoder over an eligibility mask with an exclude index. It is instantiated twice, for auto1 and auto2.

## Test plan
- Load a board with symbols 0..7 paired at indices k and k+8; select cursor 3, then cursor 11; pulse match_found_i → cards_match_o=1 before the edge, matched bits 3 and 11 set, score0_o=1, match_happened_o pulses one cycle later.
- Select 0, then 1 (mismatch), pulse start_pause_i with PAUSE_CYCLES=5 → pause_done_o high exactly 5 cycles later; end_turn_i → face_up 0 and 1 cleared, player_o=1.
- Mark cards 0–2 matched and card 4 face-up → auto1=3. With first_idx=3, auto2=5. When every card is matched → auto_pick1_valid_o=0 and game_over_o=1.
- Assert rst_n low during a pause → no pause_done_o pulse; all outputs return to reset values.
- Select cursor on a face-up card → sel_ok_o=0 and the pick is ignored; with MEMORY_STREAK_BONUS_EN, two matches in one turn give score 3, and with score 14 at SCORE_W=4 the score saturates at 15.
